sda_tx4: RTL and testbench
==========================

SDA_TX4 -- requirements
Module: sda_tx4

Interface
REQ-001 Parameter HALF, default 4, SHALL set the length of each scl half-period in clk cycles (legal range 1..255).
REQ-002 clk  input  1  sole clock; every register updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req  input  1  frame request, sampled on clk rising edges.
REQ-005 data  input  4  nibble to transmit, captured together with an accepted req.
REQ-006 scl  output  1  serial clock line, registered.
REQ-007 sda  output  1  serial data line, registered, push-pull.
REQ-008 busy  output  1  high from frame acceptance until the stop edge.
REQ-009 done  output  1  one-cycle pulse on the cycle the stop edge is driven.

Function
REQ-010 States SHALL be IDLE, START, BIT_LO, BIT_HI, STOP_LO and STOP_HI.
REQ-011 In IDLE, scl=1, sda=1, busy=0 and done=0.
REQ-012 At edge E0, with the block in IDLE and req=1, it SHALL latch data into a 4-bit shift register, clear the divider, drive sda=0 (scl stays 1), set busy=1 and enter START; this is the start condition.
REQ-013 The divider SHALL raise an internal tick every HALF clk cycles after the state entry or clear; every state transition below occurs only on a tick.
REQ-014 START->BIT_LO at E0+HALF: scl=0 and sda=shreg[3] (MSB first), both driven on the same edge.
REQ-015 BIT_LO->BIT_HI: scl=1, sda held.
REQ-016 BIT_HI, bit index not 0: go to BIT_LO, shift left, decrement the index, drive scl=0 and sda=new shreg[3].
REQ-017 BIT_HI, bit index 0: go to STOP_LO and drive scl=0, sda=0.
REQ-018 sda SHALL change only while scl=0, except at the start and stop edges.
REQ-019 STOP_LO->STOP_HI: scl=1, sda=0.
REQ-020 STOP_HI->IDLE at E0+11*HALF: sda=1 (stop condition), busy=0, done=1 for exactly one cycle.
REQ-021 scl rising edges SHALL occur at E0+2, 4, 6, 8 and 10 times HALF; the first four carry bits 3..0.
REQ-022 req while busy=1 SHALL be ignored, with no queuing; data changes during a frame SHALL not affect it.
REQ-023 req=1 on the cycle done=1 SHALL be ignored; req held high SHALL start the next frame on the following edge.
REQ-024 HALF=1 SHALL work: each state lasts one cycle and the frame takes 11 cycles.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, scl=1, sda=1, busy=0, done=0, shift register 0, bit index 3 and divider 0, regardless of state.
REQ-026 Reset mid-frame SHALL abort the frame with no done pulse; the resulting sda rise while scl=1 is accepted as a stop condition.
REQ-027 After rst_n deasserts, the first req SHALL be honoured on the first clk rising edge.

Structure
REQ-028 A shared package SHALL hold the state enumeration, the default HALF and the frame length constant (11 half-periods).
REQ-029 The HALF divider SHALL be a sub-module sda_tick (inputs clk, rst_n, clr; output tick); the FSM and shift register stay in sda_tx4.

Verification (HALF=4 unless stated)
REQ-030 Reset, then idle for 20 cycles -> scl=1, sda=1, busy=0, done never asserted.
REQ-031 data=4'b1010, req pulse at E0 -> sda falls at E0; sda is 1, 0, 1, 0 at scl rises E0+8, 16, 24, 32; scl rises at E0+40; sda rises and done=1 at E0+44; busy=0 at E0+44.
REQ-032 data=4'b0001, then req pulses at E0+10 and E0+30 with data=4'b1111 -> both pulses ignored, frame sends 0001, and exactly one done pulse occurs.
REQ-033 req held high with data=4'b0110 -> back-to-back frames, each 44 cycles; the next start edge falls one cycle after each done.
REQ-034 Frame with data=4'b1111, rst_n=0 at E0+18 -> scl=1, sda=1, busy=0 immediately; no done pulse; a new req after release sends a full frame.
REQ-035 HALF=1, data=4'b1001 -> sda falls at E0, done at E0+11, and the receiver model decodes 4'b1001.

Source files
------------

// File: rtl/sda_tx4_pkg.sv
// Shared constants for the 4-bit serial-data transmitter: state codes,
// default half-period length and frame length in half-periods.
package sda_tx4_pkg;

  localparam int unsigned HALF_DEFAULT = 4;
  localparam int unsigned FRAME_HALVES = 11;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned DATA_W       = 4;
  localparam int unsigned IDX_W        = 2;
  localparam int unsigned STATE_W      = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_START   = 3'd1;
  localparam logic [STATE_W-1:0] ST_BIT_LO  = 3'd2;
  localparam logic [STATE_W-1:0] ST_BIT_HI  = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP_LO = 3'd4;
  localparam logic [STATE_W-1:0] ST_STOP_HI = 3'd5;

endpackage

// File: rtl/sda_tick.sv
// Half-period divider: tick is high for the cycle that ends every HALF
// clocks after the last clear; it is registered so HALF=1 gives a steady tick.
module sda_tick
  import sda_tx4_pkg::*;
#(
  parameter int unsigned HALF = HALF_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Count 0..HALF-1 and wrap; a clear restarts the half-period.
  always_comb begin
    cnt_nxt = '0;
    if (!clr && (cnt != LAST)) cnt_nxt = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/sda_tx4.sv
// Serial transmitter: start condition, four MSB-first data bits clocked on
// scl, then a stop condition; busy spans the frame and done marks the stop.
module sda_tx4
  import sda_tx4_pkg::*;
#(
  parameter int unsigned HALF = HALF_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [DATA_W-1:0] data,
  output logic              scl,
  output logic              sda,
  output logic              busy,
  output logic              done
);

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  shreg, shreg_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               scl_nxt, sda_nxt, busy_nxt, done_nxt;
  logic               clr;
  logic               tick;

  sda_tick #(.HALF(HALF)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      shreg <= '0;
      idx   <= IDX_W'(3);
      scl   <= 1'b1;
      sda   <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      idx   <= idx_nxt;
      scl   <= scl_nxt;
      sda   <= sda_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Divider is held clear while idle so the start edge begins a fresh half-period.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    idx_nxt   = idx;
    scl_nxt   = scl;
    sda_nxt   = sda;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    clr       = 1'b0;

    case (state)
      ST_IDLE: begin
        clr      = 1'b1;
        scl_nxt  = 1'b1;
        sda_nxt  = 1'b1;
        busy_nxt = 1'b0;
        if (req) begin
          shreg_nxt = data;
          idx_nxt   = IDX_W'(3);
          sda_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          scl_nxt   = 1'b0;
          sda_nxt   = shreg[DATA_W-1];
          state_nxt = ST_BIT_LO;
        end
      end
      ST_BIT_LO: begin
        if (tick) begin
          scl_nxt   = 1'b1;
          state_nxt = ST_BIT_HI;
        end
      end
      ST_BIT_HI: begin
        if (tick) begin
          scl_nxt = 1'b0;
          if (idx != '0) begin
            shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
            idx_nxt   = idx - IDX_W'(1);
            sda_nxt   = shreg[DATA_W-2];
            state_nxt = ST_BIT_LO;
          end else begin
            sda_nxt   = 1'b0;
            state_nxt = ST_STOP_LO;
          end
        end
      end
      ST_STOP_LO: begin
        if (tick) begin
          scl_nxt   = 1'b1;
          sda_nxt   = 1'b0;
          state_nxt = ST_STOP_HI;
        end
      end
      ST_STOP_HI: begin
        if (tick) begin
          sda_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sda_tx4.sv
// Bench for sda_tx4: HALF=4 and HALF=1 instances checked every cycle against a
// time-based frame model, plus literal waveform points and a bit receiver.
module tb_sda_tx4;

  logic       clk = 1'b0;
  logic [1:0] rst_n_v;
  logic [1:0] req_v;
  logic [3:0] data_v [2];
  logic [1:0] scl_v, sda_v, busy_v, done_v;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sda_tx4 #(.HALF(4)) dut4 (
    .clk(clk), .rst_n(rst_n_v[0]), .req(req_v[0]), .data(data_v[0]),
    .scl(scl_v[0]), .sda(sda_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  sda_tx4 #(.HALF(1)) dut1 (
    .clk(clk), .rst_n(rst_n_v[1]), .req(req_v[1]), .data(data_v[1]),
    .scl(scl_v[1]), .sda(sda_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  // Frame model: expected lines follow from elapsed time since the start edge.
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int H = (g == 0) ? 4 : 1;
    logic       act;
    logic       dn;
    int         ph;
    logic [3:0] dat;
    int         k;
    logic       e_scl, e_sda, e_busy, e_done;

    always @(posedge clk or negedge rst_n_v[g]) begin
      if (!rst_n_v[g]) begin
        act <= 1'b0;
        dn  <= 1'b0;
        ph  <= 0;
      end else begin
        dn <= 1'b0;
        if (act) begin
          ph <= ph + 1;
          if (ph + 1 == 11 * H) begin
            act <= 1'b0;
            dn  <= 1'b1;
          end
        end else if (req_v[g]) begin
          act <= 1'b1;
          ph  <= 0;
          dat <= data_v[g];
        end
      end
    end

    always_comb begin
      k      = 0;
      e_scl  = 1'b1;
      e_sda  = 1'b1;
      e_busy = 1'b0;
      e_done = dn;
      if (act) begin
        k      = ph / H;
        e_busy = 1'b1;
        e_done = 1'b0;
        if (k == 0) begin
          e_sda = 1'b0;
        end else if (k <= 8) begin
          e_scl = (k % 2 == 0);
          e_sda = dat[3 - (k - 1) / 2];
        end else begin
          e_sda = 1'b0;
          e_scl = (k == 10);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, a, e, $time);
    end
  endtask

  // Receiver: samples sda on the first four scl rises of each frame.
  logic [3:0] rx [2];
  logic [3:0] rx_last [2];
  int         rxn [2];
  int         done_cnt [2];
  logic [1:0] prev_scl, prev_busy;

  initial begin
    for (int g = 0; g < 2; g++) begin
      rx[g] = '0; rx_last[g] = '0; rxn[g] = 0; done_cnt[g] = 0;
    end
    prev_scl  = 2'b11;
    prev_busy = 2'b00;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("scl_h4",  scl_v[0],  mdl[0].e_scl);
      chk("sda_h4",  sda_v[0],  mdl[0].e_sda);
      chk("busy_h4", busy_v[0], mdl[0].e_busy);
      chk("done_h4", done_v[0], mdl[0].e_done);
      chk("scl_h1",  scl_v[1],  mdl[1].e_scl);
      chk("sda_h1",  sda_v[1],  mdl[1].e_sda);
      chk("busy_h1", busy_v[1], mdl[1].e_busy);
      chk("done_h1", done_v[1], mdl[1].e_done);
    end
    for (int g = 0; g < 2; g++) begin
      if (busy_v[g] === 1'b1 && prev_busy[g] !== 1'b1) begin
        rx[g]  = '0;
        rxn[g] = 0;
      end else if (busy_v[g] === 1'b1 && scl_v[g] === 1'b1 && prev_scl[g] === 1'b0 && rxn[g] < 4) begin
        rx[g]  = {rx[g][2:0], sda_v[g]};
        rxn[g] = rxn[g] + 1;
      end
      if (done_v[g] === 1'b1) begin
        done_cnt[g] = done_cnt[g] + 1;
        rx_last[g]  = rx[g];
      end
      prev_scl[g]  = scl_v[g];
      prev_busy[g] = busy_v[g];
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int g, input int maxc, output int dc);
    dc = -1;
    for (int i = 0; i < maxc; i++) begin
      step(1);
      if (done_v[g] === 1'b1) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout inst=%0d got=none want=pulse within %0d cycles", g, maxc);
    end
  endtask

  int s, d, d2, dc0;

  initial begin
    rst_n_v = 2'b11;
    req_v   = 2'b00;
    data_v[0] = '0;
    data_v[1] = '0;
    #2 rst_n_v = 2'b00;
    step(3);
    chk_en = 1'b1;
    chk("rst_scl", scl_v[0], 1'b1);
    chk("rst_sda", sda_v[0], 1'b1);
    chk("rst_busy", busy_v[0], 1'b0);
    rst_n_v = 2'b11;

    // Idle for 20 cycles
    step(20);
    chk("idle_scl", scl_v[0], 1'b1);
    chk("idle_sda", sda_v[0], 1'b1);
    chk("idle_busy", busy_v[0], 1'b0);
    chk_int("idle_dones", done_cnt[0] + done_cnt[1], 0);

    // Frame 1010 with literal waveform points
    data_v[0] = 4'b1010; req_v[0] = 1'b1;
    step(1); s = cyc;
    req_v[0] = 1'b0;
    chk("f1_start_sda", sda_v[0], 1'b0);
    chk("f1_start_scl", scl_v[0], 1'b1);
    chk("f1_start_busy", busy_v[0], 1'b1);
    step(8);  chk("f1_b3", sda_v[0], 1'b1); chk("f1_r8", scl_v[0], 1'b1);
    step(8);  chk("f1_b2", sda_v[0], 1'b0); chk("f1_r16", scl_v[0], 1'b1);
    step(8);  chk("f1_b1", sda_v[0], 1'b1); chk("f1_r24", scl_v[0], 1'b1);
    step(8);  chk("f1_b0", sda_v[0], 1'b0); chk("f1_r32", scl_v[0], 1'b1);
    step(8);  chk("f1_r40_scl", scl_v[0], 1'b1); chk("f1_r40_sda", sda_v[0], 1'b0);
    step(3);  chk("f1_43_done", done_v[0], 1'b0); chk("f1_43_sda", sda_v[0], 1'b0);
    step(1);  chk("f1_44_done", done_v[0], 1'b1); chk("f1_44_sda", sda_v[0], 1'b1);
    chk("f1_44_busy", busy_v[0], 1'b0);
    chk_int("f1_len", cyc - s, 44);
    step(1);  chk("f1_45_done", done_v[0], 1'b0);
    chk("f1_rx", rx_last[0] == 4'b1010, 1'b1);
    step(5);

    // Requests during a frame are ignored
    dc0 = done_cnt[0];
    data_v[0] = 4'b0001; req_v[0] = 1'b1;
    step(1); s = cyc;
    req_v[0] = 1'b0;
    step(9);  req_v[0] = 1'b1; data_v[0] = 4'b1111;
    step(1);  req_v[0] = 1'b0;
    step(19); req_v[0] = 1'b1;
    step(1);  req_v[0] = 1'b0;
    wait_done(0, 60, d);
    chk_int("f2_len", d - s, 44);
    step(20);
    chk_int("f2_done_cnt", done_cnt[0] - dc0, 1);
    chk("f2_rx", rx_last[0] == 4'b0001, 1'b1);

    // Held request: back-to-back frames
    data_v[0] = 4'b0110; req_v[0] = 1'b1;
    step(1); s = cyc;
    wait_done(0, 60, d);
    chk_int("f3_len", d - s, 44);
    step(1);
    chk("f3_next_start_sda", sda_v[0], 1'b0);
    chk("f3_next_start_busy", busy_v[0], 1'b1);
    chk("f3_rx", rx_last[0] == 4'b0110, 1'b1);
    wait_done(0, 60, d2);
    req_v[0] = 1'b0;
    chk_int("f3_gap", d2 - d, 45);
    step(10);
    chk("f3_end_idle", busy_v[0], 1'b0);

    // Reset mid-frame aborts with no done
    dc0 = done_cnt[0];
    data_v[0] = 4'b1111; req_v[0] = 1'b1;
    step(1);
    req_v[0] = 1'b0;
    step(18);
    rst_n_v[0] = 1'b0;
    #1;
    chk("rst_mid_scl", scl_v[0], 1'b1);
    chk("rst_mid_sda", sda_v[0], 1'b1);
    chk("rst_mid_busy", busy_v[0], 1'b0);
    step(3);
    chk_int("rst_mid_no_done", done_cnt[0] - dc0, 0);
    rst_n_v[0] = 1'b1; data_v[0] = 4'b0011; req_v[0] = 1'b1;
    step(1); s = cyc;
    req_v[0] = 1'b0;
    chk("rst_rel_busy", busy_v[0], 1'b1);
    chk("rst_rel_sda", sda_v[0], 1'b0);
    wait_done(0, 60, d);
    chk_int("rst_rel_len", d - s, 44);
    step(1);
    chk("rst_rel_rx", rx_last[0] == 4'b0011, 1'b1);

    // HALF=1 instance
    data_v[1] = 4'b1001; req_v[1] = 1'b1;
    step(1); s = cyc;
    req_v[1] = 1'b0;
    chk("h1_start_sda", sda_v[1], 1'b0);
    wait_done(1, 20, d);
    chk_int("h1_len", d - s, 11);
    step(2);
    chk("h1_rx", rx_last[1] == 4'b1001, 1'b1);
    chk_int("h1_done_cnt", done_cnt[1], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
